// File: rtl/regfile_dump.sv
// Read-side dump sequencer for the register file: walks an inclusive (wrapping)
// address range and streams {address, data} beats on a valid/ready interface.
module regfile_dump #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [REG_WIDTH-1:0]  rf_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [REG_WIDTH-1:0]  out_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_end;
    logic [ADDR_WIDTH-1:0]   r_cur;
    logic [ADDR_WIDTH-1:0]   r_raddr;
    logic [ADDR_WIDTH-1:0]   r_outAddr;
    logic [REG_WIDTH-1:0]    r_outData;
    logic [ADDR_WIDTH-1:0]   w_curInc;
    logic                    w_handshake;
    logic                    w_last;

    assign w_curInc    = r_cur + 1'b1;
    assign w_handshake = (r_state == S_SEND) && out_ready;
    assign w_last      = (r_cur == r_end);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort outranks a same-cycle handshake so an aborted beat is never consumed.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: w_next = abort ? S_IDLE : S_SEND;
            S_SEND: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_handshake) begin
                    w_next = w_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_end     <= '0;
            r_cur     <= '0;
            r_raddr   <= '0;
            r_outAddr <= '0;
            r_outData <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_end   <= end_addr;
                        r_cur   <= start_addr;
                        r_raddr <= start_addr;
                    end
                end
                S_FETCH: begin
                    if (!abort) begin
                        r_outData <= rf_rdata;
                        r_outAddr <= r_cur;
                    end
                end
                S_SEND: begin
                    if (!abort && w_handshake && !w_last) begin
                        r_cur   <= w_curInc;
                        r_raddr <= w_curInc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rf_raddr  = r_raddr;
    assign out_addr  = r_outAddr;
    assign out_data  = r_outData;
    assign out_valid = (r_state == S_SEND);
    assign busy      = (r_state == S_FETCH) || (r_state == S_SEND);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: directed dumps push expected beats into a
// queue, an independent monitor pops and compares on every accepted beat.
module tb_regfile_dump;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] start_addr;
    logic [3:0] end_addr;
    logic [3:0] rf_raddr;
    logic [7:0] rf_rdata;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_addr;
    logic [7:0] out_data;
    logic       busy;
    logic       done;

    logic [7:0]  regs [16];
    logic [11:0] expQ [$];
    int          errors = 0;
    int          checks = 0;
    int          beatCount = 0;
    int          doneCount = 0;

    regfile_dump #(.REG_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .start_addr(start_addr), .end_addr(end_addr),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
    );

    assign rf_rdata = regs[rf_raddr];

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: pops one expected beat per accepted handshake and checks stalls hold steady.
    initial begin
        logic        heldValid;
        logic [3:0]  heldAddr;
        logic [7:0]  heldData;
        logic [11:0] item;
        heldValid = 1'b0;
        heldAddr  = '0;
        heldData  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                heldValid = 1'b0;
            end else begin
                if (done) doneCount++;
                if (out_valid) begin
                    if (heldValid) begin
                        checkOutput("stallAddr", out_addr, heldAddr);
                        checkOutput("stallData", out_data, heldData);
                    end
                    if (out_ready && !abort) begin
                        if (expQ.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpectedBeat: got addr %0h data %0h expected none", out_addr, out_data);
                        end else begin
                            item = expQ.pop_front();
                            checkOutput("beatAddr", out_addr, item[11:8]);
                            checkOutput("beatData", out_data, item[7:0]);
                        end
                        beatCount++;
                        heldValid = 1'b0;
                    end else begin
                        heldValid = 1'b1;
                        heldAddr  = out_addr;
                        heldData  = out_data;
                    end
                end else begin
                    heldValid = 1'b0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] s, input logic [3:0] e);
        logic [3:0] a;
        a = s;
        for (int k = 0; k < 16; k++) begin
            expQ.push_back({a, regs[a]});
            if (a == e) break;
            a = a + 4'd1;
        end
        @(posedge clk); #1;
        start_addr = s;
        end_addr   = e;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        start_addr = 4'd0;
        end_addr   = 4'd0;
    endtask

    task automatic waitDone(input string name, input int limit, output int cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no done pulse expected one within %0d cycles", name, limit);
        end
    endtask

    task automatic waitBeat(input logic [3:0] addr, input int limit);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < limit && !seen; c++) begin
            @(negedge clk);
            if (out_valid && out_addr == addr) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitBeat: got no beat expected addr %0h", addr);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        int beatsBefore;
        int doneBefore;
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b1;
        start_addr = 4'd0;
        end_addr   = 4'd0;
        for (int i = 0; i < 16; i++) regs[i] = 8'(3 * i);

        #12;
        checkOutput("rstValid", out_valid, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstRaddr", rf_raddr, 0);
        checkOutput("rstOutAddr", out_addr, 0);
        checkOutput("rstOutData", out_data, 0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] full range 0..15");
        beatsBefore = beatCount;
        doneBefore  = doneCount;
        applyStimulus(4'd0, 4'd15);
        waitDone("fullDone", 100, cycles);
        checkOutput("fullCycles", cycles, 33);
        repeat (3) @(negedge clk);
        checkOutput("fullBeats", beatCount - beatsBefore, 16);
        checkOutput("fullDoneOnce", doneCount - doneBefore, 1);
        checkOutput("fullBusyAfter", busy, 0);
        checkOutput("fullQueueEmpty", expQ.size(), 0);

        $display("[TB] range 2..4 with stall on beat 3");
        doneBefore = doneCount;
        applyStimulus(4'd2, 4'd4);
        waitBeat(4'd2, 20);
        @(posedge clk); #1;
        out_ready = 1'b0;
        waitBeat(4'd3, 20);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("stallValid", out_valid, 1);
            checkOutput("stallBeatAddr", out_addr, 3);
            checkOutput("stallBeatData", out_data, 8'h09);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        waitDone("stallDone", 40, cycles);
        repeat (3) @(negedge clk);
        checkOutput("stallDoneOnce", doneCount - doneBefore, 1);
        checkOutput("stallQueueEmpty", expQ.size(), 0);

        $display("[TB] wrap range 14..1");
        beatsBefore = beatCount;
        applyStimulus(4'd14, 4'd1);
        waitDone("wrapDone", 40, cycles);
        checkOutput("wrapCycles", cycles, 9);
        repeat (2) @(negedge clk);
        checkOutput("wrapBeats", beatCount - beatsBefore, 4);
        checkOutput("wrapQueueEmpty", expQ.size(), 0);

        $display("[TB] single register 5..5");
        beatsBefore = beatCount;
        applyStimulus(4'd5, 4'd5);
        waitDone("singleDone", 20, cycles);
        checkOutput("singleCycles", cycles, 3);
        repeat (2) @(negedge clk);
        checkOutput("singleBeats", beatCount - beatsBefore, 1);

        $display("[TB] restart attempt during full dump");
        beatsBefore = beatCount;
        doneBefore  = doneCount;
        applyStimulus(4'd0, 4'd15);
        repeat (6) @(posedge clk);
        #1;
        start_addr = 4'd9;
        end_addr   = 4'd10;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        waitDone("restartDone", 100, cycles);
        repeat (6) @(negedge clk);
        checkOutput("restartBeats", beatCount - beatsBefore, 16);
        checkOutput("restartDoneOnce", doneCount - doneBefore, 1);
        checkOutput("restartQueueEmpty", expQ.size(), 0);

        $display("[TB] async reset mid-dump");
        applyStimulus(4'd0, 4'd15);
        waitBeat(4'd4, 40);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midRstValid", out_valid, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstAddr", out_addr, 0);
        checkOutput("midRstData", out_data, 0);
        checkOutput("midRstRaddr", rf_raddr, 0);
        expQ.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        beatsBefore = beatCount;
        applyStimulus(4'd7, 4'd8);
        waitDone("postRstDone", 20, cycles);
        checkOutput("postRstCycles", cycles, 5);
        repeat (2) @(negedge clk);
        checkOutput("postRstBeats", beatCount - beatsBefore, 2);
        checkOutput("postRstQueueEmpty", expQ.size(), 0);

        $display("[TB] abort during beat 3");
        beatsBefore = beatCount;
        doneBefore  = doneCount;
        applyStimulus(4'd0, 4'd5);
        waitBeat(4'd2, 20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("abortPreValid", out_valid, 1);
        checkOutput("abortPreAddr", out_addr, 3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abortValid", out_valid, 0);
        checkOutput("abortBusy", busy, 0);
        repeat (5) @(negedge clk);
        checkOutput("abortNoDone", doneCount - doneBefore, 0);
        checkOutput("abortBeats", beatCount - beatsBefore, 3);
        checkOutput("abortLeftover", expQ.size(), 3);
        expQ.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
